// File: rtl/div_iter.sv
// Iterative 32-bit divider for div/divu in the E stage.
// One restoring radix-2 step per cycle; stalls the front end while busy.
module div_iter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        startE,
  input  logic        signedE,
  input  logic        annulE,
  input  logic [31:0] opaE,
  input  logic [31:0] opbE,
  output logic        stall_divE,
  output logic        validE,
  output logic [31:0] hiE,
  output logic [31:0] loE
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t      state;
  state_t      nextState;
  logic        go;
  logic [5:0]  cnt;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvsr;
  logic        sgn;
  logic        signA;
  logic        signB;
  logic        divZero;
  logic [31:0] magA;
  logic [31:0] magB;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        fits;
  logic [31:0] remNext;
  logic [31:0] quoNext;
  logic [31:0] qFix;
  logic [31:0] rFix;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState  = state;
    stall_divE = 1'b0;
    validE     = 1'b0;
    go         = 1'b0;
    unique case (state)
      IDLE: begin
        if (startE && !annulE) begin
          go         = 1'b1;
          stall_divE = 1'b1;
          nextState  = BUSY;
        end
      end
      BUSY: begin
        stall_divE = !annulE;
        if (cnt == 6'd31) nextState = DONE;
      end
      DONE: begin
        validE    = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
    if (annulE) nextState = IDLE;
  end

  assign magA = (signedE && opaE[31]) ? -opaE : opaE;
  assign magB = (signedE && opbE[31]) ? -opbE : opbE;

  // partial remainder stays below the divisor, so bit 32 of diff is the borrow
  assign shifted = {rem, quo[31]};
  assign diff    = shifted - {1'b0, dvsr};
  assign fits    = !diff[32];
  assign remNext = fits ? diff[31:0] : shifted[31:0];
  assign quoNext = {quo[30:0], fits};

  // remainder fix also restores the raw dividend for a zero divisor
  assign qFix = divZero ? 32'hFFFF_FFFF
              : (sgn && (signA ^ signB)) ? -quoNext : quoNext;
  assign rFix = (sgn && signA) ? -remNext : remNext;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvsr    <= '0;
      sgn     <= 1'b0;
      signA   <= 1'b0;
      signB   <= 1'b0;
      divZero <= 1'b0;
      hiE     <= '0;
      loE     <= '0;
    end else if (go) begin
      cnt     <= '0;
      rem     <= '0;
      quo     <= magA;
      dvsr    <= magB;
      sgn     <= signedE;
      signA   <= opaE[31];
      signB   <= opbE[31];
      divZero <= (opbE == 32'd0);
    end else if (state == BUSY && !annulE) begin
      if (cnt == 6'd31) begin
        cnt <= '0;
        hiE <= rFix;
        loE <= qFix;
      end else begin
        cnt <= cnt + 6'd1;
        rem <= remNext;
        quo <= quoNext;
      end
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter.
// Hand-computed quotient/remainder vectors plus stall/valid timing.
module tb_div_iter;

  logic        clk;
  logic        resetn;
  logic        startE;
  logic        signedE;
  logic        annulE;
  logic [31:0] opaE;
  logic [31:0] opbE;
  logic        stall_divE;
  logic        validE;
  logic [31:0] hiE;
  logic [31:0] loE;

  int checks;
  int failures;

  div_iter dut (
    .clk        (clk),
    .resetn     (resetn),
    .startE     (startE),
    .signedE    (signedE),
    .annulE     (annulE),
    .opaE       (opaE),
    .opbE       (opbE),
    .stall_divE (stall_divE),
    .validE     (validE),
    .hiE        (hiE),
    .loE        (loE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one divide: start for one cycle, scramble operands afterwards
  task automatic runDiv(input string tag, input logic [31:0] a,
                        input logic [31:0] b, input logic s,
                        input logic [31:0] expLo, input logic [31:0] expHi);
    int stallBad;
    int validCnt;
    int validAt;
    stallBad = 0;
    validCnt = 0;
    validAt  = 0;
    @(negedge clk);
    startE  = 1'b1;
    signedE = s;
    opaE    = a;
    opbE    = b;
    for (int c = 1; c <= 36; c++) begin
      #1;
      if (stall_divE !== (c <= 33)) stallBad++;
      if (validE === 1'b1) begin
        validCnt++;
        validAt = c;
      end
      @(negedge clk);
      if (c == 1) begin
        startE  = 1'b0;
        signedE = ~s;
        opaE    = $urandom;
        opbE    = $urandom;
      end
    end
    chk({tag, "_stall33"}, stallBad, 0);
    chk({tag, "_validcnt"}, validCnt, 1);
    chk({tag, "_validat"}, validAt, 34);
    chk({tag, "_lo"}, loE, expLo);
    chk({tag, "_hi"}, hiE, expHi);
  endtask

  initial begin
    int bad;
    int validCnt;
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    startE   = 1'b0;
    signedE  = 1'b0;
    annulE   = 1'b0;
    opaE     = '0;
    opbE     = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", {31'd0, stall_divE}, 32'd0);
    chk("rst_valid", {31'd0, validE}, 32'd0);
    chk("rst_hi", hiE, 32'd0);
    chk("rst_lo", loE, 32'd0);
    resetn = 1'b1;

    runDiv("s7_m2", 32'h0000_0007, 32'hFFFF_FFFE, 1'b1,
           32'hFFFF_FFFD, 32'h0000_0001);
    runDiv("u_ff_16", 32'hFFFF_FFFF, 32'h0000_0010, 1'b0,
           32'h0FFF_FFFF, 32'h0000_000F);
    runDiv("s_m7_2", 32'hFFFF_FFF9, 32'h0000_0002, 1'b1,
           32'hFFFF_FFFD, 32'hFFFF_FFFF);
    runDiv("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
           32'h8000_0000, 32'h0000_0000);
    runDiv("u_dz", 32'h0000_1234, 32'h0000_0000, 1'b0,
           32'hFFFF_FFFF, 32'h0000_1234);
    runDiv("s_dz", 32'h0000_1234, 32'h0000_0000, 1'b1,
           32'hFFFF_FFFF, 32'h0000_1234);
    runDiv("s_dzneg", 32'hFFFF_FFF0, 32'h0000_0000, 1'b1,
           32'hFFFF_FFFF, 32'hFFFF_FFF0);

    // annul on the tenth busy cycle
    @(negedge clk);
    startE  = 1'b1;
    signedE = 1'b0;
    opaE    = 32'd1000;
    opbE    = 32'd3;
    @(negedge clk);
    startE = 1'b0;
    repeat (9) @(negedge clk);
    annulE = 1'b1;
    #1;
    chk("annul_stall", {31'd0, stall_divE}, 32'd0);
    @(negedge clk);
    annulE   = 1'b0;
    validCnt = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (validE === 1'b1) validCnt++;
      @(negedge clk);
    end
    chk("annul_novalid", validCnt, 0);
    chk("annul_lo_hold", loE, 32'hFFFF_FFFF);
    chk("annul_hi_hold", hiE, 32'hFFFF_FFF0);
    runDiv("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);

    // asynchronous reset in the middle of a divide
    @(negedge clk);
    startE  = 1'b1;
    signedE = 1'b0;
    opaE    = 32'd5;
    opbE    = 32'd1;
    @(negedge clk);
    startE = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("midrst_stall", {31'd0, stall_divE}, 32'd0);
    chk("midrst_valid", {31'd0, validE}, 32'd0);
    chk("midrst_hi", hiE, 32'd0);
    chk("midrst_lo", loE, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // back-to-back: startE held, second op begins right after DONE
    @(negedge clk);
    startE   = 1'b1;
    signedE  = 1'b0;
    opaE     = 32'd1000;
    opbE     = 32'd10;
    bad      = 0;
    validCnt = 0;
    for (int c = 1; c <= 68; c++) begin
      #1;
      if (stall_divE !== !(c == 34 || c == 68)) bad++;
      if (validE === 1'b1 && (c == 34 || c == 68)) validCnt++;
      else if (validE !== 1'b0) bad++;
      if (c == 35) begin
        chk("b2b_lo1", loE, 32'd100);
        chk("b2b_hi1", hiE, 32'd0);
      end
      @(negedge clk);
      if (c == 1) begin
        signedE = 1'b1;
        opaE    = 32'hFFFF_FFF6;
        opbE    = 32'd3;
      end
      if (c == 68) startE = 1'b0;
    end
    #1;
    chk("b2b_timing", bad, 0);
    chk("b2b_validcnt", validCnt, 2);
    chk("b2b_lo2", loE, 32'hFFFF_FFFD);
    chk("b2b_hi2", hiE, 32'hFFFF_FFFF);
    chk("b2b_idle", {31'd0, stall_divE}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 SHALL provide port: clk  in  1  rising-edge clock.
REQ-002 SHALL provide port: resetn  in  1  asynchronous, active-low reset.
REQ-003 SHALL provide port: startE  in  1  div/divu instruction present in E stage.
REQ-004 SHALL provide port: signedE  in  1  1=div (signed), 0=divu; sampled with startE.
REQ-005 SHALL provide port: annulE  in  1  exception flush; cancels any operation.
REQ-006 SHALL provide port: opaE  in  32  dividend (rs value after forwarding).
REQ-007 SHALL provide port: opbE  in  32  divisor (rt value after forwarding).
REQ-008 SHALL provide port: stall_divE  out  1  hold F/D/E stages; feeds hazard unit stallE/stallD/stallF.
REQ-009 SHALL provide port: validE  out  1  one-cycle pulse; hiE/loE hold the new result.
REQ-010 SHALL provide port: hiE  out  32  remainder, written to HI with mdToHilo.
REQ-011 SHALL provide port: loE  out  32  quotient, written to LO with mdToHilo.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 IDLE SHALL move to BUSY when startE=1 and annulE=0.
- Same edge: latch |opaE| and |opbE|, result-sign flags, signedE, divisor-zero flag.
- Magnitudes are taken only when signedE=1.
REQ-014 BUSY SHALL run one restoring radix-2 step per cycle.
- 6-bit counter 0..31.
- Counter value 31 moves to DONE.
REQ-015 DONE SHALL return to IDLE unconditionally on the next edge.
- No restart from DONE, even if startE is still 1.
REQ-016 stall_divE SHALL be combinational.
- 1 when (IDLE & startE & ~annulE) or BUSY.
- 0 in DONE, so the divide leaves E after DONE.
- Asserted for exactly 33 consecutive cycles per divide.
REQ-017 validE SHALL be 1 only in DONE, for exactly one cycle, on the 34th cycle counted from the start cycle.
REQ-018 hiE/loE SHALL update only on the edge entering DONE.
- Otherwise hold the last result.
- Hold through IDLE until the next DONE.
REQ-019 Signed sign fix SHALL be: quotient negated iff sign(a)^sign(b); remainder negated iff sign(a).
REQ-020 Unsigned mode SHALL use raw 32-bit operands with no sign fix.
REQ-021 0x80000000 / 0xFFFFFFFF signed SHALL yield lo=0x80000000, hi=0; no exception raised.
REQ-022 Divisor zero SHALL yield lo=0xFFFFFFFF and hi=captured raw dividend, in both modes.
- Latency unchanged (33 stall cycles).
REQ-023 annulE=1 in any state SHALL force IDLE on the next edge.
- Same cycle: stall_divE=0.
- No validE for that operation.
- hiE/loE unchanged.
REQ-024 Operand or signedE changes after the start cycle SHALL have no effect on the result.
REQ-025 A new startE in the cycle after DONE SHALL begin a fresh operation with no idle gap required.

Reset
REQ-026 resetn=0 SHALL asynchronously force IDLE, counter=0, hiE=0, loE=0, validE=0, stall_divE=0.
- Applies regardless of state, including mid-BUSY.
REQ-027 After resetn deassertion, the first startE SHALL behave exactly as REQ-013 to REQ-017.

Verification
REQ-028 Signed 7 / -2 (opaE=0x00000007, opbE=0xFFFFFFFE, signedE=1) -> stall_divE high 33 cycles, validE on cycle 34, loE=0xFFFFFFFD, hiE=0x00000001.
REQ-029 Unsigned 0xFFFFFFFF / 0x00000010 -> loE=0x0FFFFFFF, hiE=0x0000000F; signed -7 / 2 -> loE=0xFFFFFFFD, hiE=0xFFFFFFFF.
REQ-030 Signed 0x80000000 / 0xFFFFFFFF -> loE=0x80000000, hiE=0x00000000.
REQ-031 0x00001234 / 0 (both modes) -> loE=0xFFFFFFFF, hiE=0x00001234, 33 stall cycles.
REQ-032 annulE pulsed on BUSY cycle 10 -> stall_divE low that cycle, no validE, hiE/loE hold old values; next start 100 / 7 unsigned -> loE=14, hiE=2.
REQ-033 resetn driven low mid-BUSY (between edges) -> stall_divE, validE, hiE, loE all 0 immediately; back-to-back divides after DONE each give 33 stall cycles.
